mem_nonzero_latency: RTL and testbench

Word-addressed, single-port behavioural memory with fixed, nonzero read and write latencies and a one-cycle `ready` completion pulse. It serves as both instruction and data memory for the stall-on-memory pipelined RV32 core and its bench. The core holds a request until `ready`, so the pipeline exercises its stall paths. Contents are preloaded and dumped hierarchically through the array `mem_array`.

---
 rtl/mem_nzlat_pkg.sv | 16 +
 rtl/mem_nonzero_latency.sv | 149 ++++++++++++++
 tb/tb_mem_nonzero_latency.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_nzlat_pkg.sv
// Shared definitions for the nonzero-latency behavioural memory.
//   mem_state_e : FSM state encoding (IDLE -> BUSY -> DONE -> IDLE)
//   max_int     : constant helper used to size the latency counter
package mem_nzlat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_nonzero_latency.sv
// Word-addressed single-port memory with fixed, nonzero read/write latency
// and a one-cycle ready pulse per transaction.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (array contents are not cleared)
//   addr   : word address, latched at acceptance
//   wdata  : write data, latched at acceptance
//   wstrb  : byte enables, bit i covers bits 8i+7:8i
//   write  : write request (wins over read when both are high)
//   read   : read request
//   rdata  : registered read data, held until the next read completes
//   ready  : registered completion pulse, high in cycle LATENCY after the
//            request cycle
//
// Handshake: a request is accepted on the first edge where the FSM is idle
// and read or write is high; inputs are then ignored until ready. The
// requester must drop or replace the request in the ready cycle, otherwise
// it is accepted again one cycle later.
module mem_nonzero_latency
  import mem_nzlat_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 1024,
  parameter int READ_LATENCY  = 5,
  parameter int WRITE_LATENCY = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [$clog2(DEPTH)-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      write,
  input  logic                      read,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      ready
);

  localparam int AW    = $clog2(DEPTH);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int LAT_W = $clog2(max_int(READ_LATENCY, WRITE_LATENCY) + 1);

  logic [DATA_WIDTH-1:0] mem_array [0:DEPTH-1];

  mem_state_e            state, state_nxt;
  logic [LAT_W-1:0]      cnt, cnt_nxt;
  logic [LAT_W-1:0]      lat_m1;

  logic [AW-1:0]         lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [NB-1:0]         lat_wstrb;
  logic                  lat_write;

  // Operation actually performed on a commit edge. Normally the latched
  // request; with a latency of one the commit happens on the accepting edge
  // itself, so the live inputs are used instead.
  logic                  accept, commit;
  logic [AW-1:0]         op_addr;
  logic [DATA_WIDTH-1:0] op_wdata;
  logic [NB-1:0]         op_wstrb;
  logic                  op_write;

  // Remaining BUSY cycles after acceptance; write takes precedence.
  assign lat_m1 = write ? LAT_W'(WRITE_LATENCY - 1) : LAT_W'(READ_LATENCY - 1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    op_addr   = lat_addr;
    op_wdata  = lat_wdata;
    op_wstrb  = lat_wstrb;
    op_write  = lat_write;
    case (state)
      IDLE: begin
        if (write || read) begin
          accept   = 1'b1;
          op_addr  = addr;
          op_wdata = wdata;
          op_wstrb = wstrb;
          op_write = write;
          if (lat_m1 == '0) begin
            commit    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt   = lat_m1;
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt <= LAT_W'(1)) begin
          commit    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - LAT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ready     <= 1'b0;
      rdata     <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
      lat_write <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ready <= (state_nxt == DONE);
      if (accept) begin
        lat_addr  <= addr;
        lat_wdata <= wdata;
        lat_wstrb <= wstrb;
        lat_write <= write;
      end
      if (commit && !op_write) begin
        rdata <= mem_array[op_addr];
      end
    end
  end

  // Storage has no reset so contents can be preloaded after reset release.
  always_ff @(posedge clk) begin
    if (commit && op_write) begin
      for (int i = 0; i < NB; i++) begin
        if (op_wstrb[i]) begin
          mem_array[op_addr][8*i +: 8] <= op_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_nonzero_latency.sv
module tb_mem_nonzero_latency;
  import mem_nzlat_pkg::*;

  localparam int RL = 5;
  localparam int WL = 5;

  logic        clk;
  logic        rst_n;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        write;
  logic        read;
  logic [31:0] rdata;
  logic        ready;

  int n_cmp;
  int n_fail;

  // Reference: word array plus the value rdata should currently hold.
  logic [31:0] model [0:1023];
  logic [31:0] rdata_model;

  mem_nonzero_latency #(
    .DATA_WIDTH(32), .DEPTH(1024), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .write(write), .read(read), .rdata(rdata), .ready(ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    read  = 1'b0;
    write = 1'b0;
    addr  = '0;
    wdata = '0;
    wstrb = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rdata_model = '0;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One transaction: request raised in cycle 0, inputs scrambled in cycle 1
  // (must be ignored), request dropped on seeing ready. Checks the ready
  // cycle, that exactly one pulse occurs, and rdata.
  task automatic txn(input logic rd, input logic wr, input logic [9:0] a,
                     input logic [31:0] wd, input logic [3:0] ws, input string tag);
    int lat;
    int seen;
    int pulses;
    logic [31:0] exp_rd;
    @(negedge clk);
    read  = rd;
    write = wr;
    addr  = a;
    wdata = wd;
    wstrb = ws;
    if (wr) begin
      lat = WL;
      for (int i = 0; i < 4; i++) begin
        if (ws[i]) model[a][8*i +: 8] = wd[8*i +: 8];
      end
    end else begin
      lat = RL;
      rdata_model = model[a];
    end
    exp_rd = rdata_model;
    seen   = -1;
    pulses = 0;
    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clk);
      if (ready) begin
        pulses++;
        if (seen < 0) seen = k;
        chk({tag, " rdata@ready"}, rdata, exp_rd);
        read  = 1'b0;
        write = 1'b0;
      end else if (k == 1) begin
        addr  = 10'($urandom);
        wdata = $urandom;
        wstrb = 4'($urandom);
      end
    end
    chk({tag, " ready_cycle"}, 32'(seen), 32'(lat));
    chk({tag, " pulses"}, 32'(pulses), 32'd1);
    chk({tag, " rdata_hold"}, rdata, exp_rd);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rdata_model = '0;
    do_reset();

    @(negedge clk);
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset state", 32'(dut.state), 32'(IDLE));
    chk("reset cnt", 32'(dut.cnt), 32'd0);

    // Known contents for words 0..15.
    for (int i = 0; i < 16; i++) txn(1'b0, 1'b1, 10'(i), $urandom, 4'hF, "preload");

    // Read latency and input latching.
    txn(1'b0, 1'b1, 10'd3, 32'h11223344, 4'hF, "wr3");
    txn(1'b1, 1'b0, 10'd3, 32'h0, 4'h0, "rd3");
    chk("rd3 literal", rdata, 32'h11223344);

    // Byte-strobe write.
    txn(1'b0, 1'b1, 10'd3, 32'hAABBCCDD, 4'b0101, "wstrb");
    txn(1'b1, 1'b0, 10'd3, 32'h0, 4'h0, "rd3b");
    chk("wstrb literal", rdata, 32'h11BB33DD);

    // Zero strobe: completes, no change.
    txn(1'b0, 1'b1, 10'd3, 32'h55555555, 4'h0, "wstrb0");
    chk("wstrb0 array", dut.mem_array[3], 32'h11BB33DD);

    // Back-to-back reads with request held, address switched on ready.
    txn(1'b0, 1'b1, 10'd1, 32'hA, 4'hF, "wr1");
    txn(1'b0, 1'b1, 10'd2, 32'hB, 4'hF, "wr2");
    @(negedge clk);
    read = 1'b1;
    addr = 10'd1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 5) begin
        chk("b2b ready c5", 32'(ready), 32'd1);
        chk("b2b rdata c5", rdata, 32'hA);
        addr = 10'd2;
      end else if (k == 11) begin
        chk("b2b ready c11", 32'(ready), 32'd1);
        chk("b2b rdata c11", rdata, 32'hB);
        read = 1'b0;
      end else begin
        chk($sformatf("b2b no ready c%0d", k), 32'(ready), 32'd0);
      end
    end
    rdata_model = 32'hB;

    // Simultaneous read+write acts as a write.
    txn(1'b1, 1'b1, 10'd4, 32'hCAFEF00D, 4'hF, "rdwr");
    chk("rdwr array", dut.mem_array[4], 32'hCAFEF00D);
    chk("rdwr rdata", rdata, 32'hB);

    // Reset in the middle of a write.
    txn(1'b0, 1'b1, 10'd5, 32'h0, 4'hF, "wr5");
    @(negedge clk);
    write = 1'b1;
    addr  = 10'd5;
    wdata = 32'hDEADBEEF;
    wstrb = 4'hF;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    write = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst ready", 32'(ready), 32'd0);
    end
    chk("rst rdata", rdata, 32'd0);
    chk("rst array5", dut.mem_array[5], 32'd0);
    chk("rst state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;
    rdata_model = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post-rst ready", 32'(ready), 32'd0);
    end
    txn(1'b1, 1'b0, 10'd5, 32'h0, 4'h0, "rd5");

    // Randomized traffic over the known words.
    for (int n = 0; n < 30; n++) begin
      logic rd_r;
      logic wr_r;
      rd_r = 1'($urandom);
      wr_r = 1'($urandom);
      if (!rd_r && !wr_r) rd_r = 1'b1;
      txn(rd_r, wr_r, 10'($urandom_range(0, 15)), $urandom, 4'($urandom),
          $sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
